// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//   Memory-side responder for the control unit's load/store commands.
//   It accepts one word, half or byte request and turns it into word-aligned
//   accesses to a synchronous fixed-latency memory.
//   - Loads: the selected lane is extracted and sign-extended into rdata.
//   - Sub-word stores: done as a read-modify-write.
//   - Misaligned requests: rejected without touching memory.
//   A one-cycle ready pulse marks completion of every request.
//
// Ports
//   clk, reset_n     clock, synchronous active-low reset
//   req              request, sampled only in IDLE
//   we               1 = store, 0 = load
//   size             00 word, 01 half, 10 byte, 11 illegal
//   addr             byte address
//   wdata            store data (half: [15:0], byte: [7:0])
//   rdata            sign-extended load result, held until the next load
//   ready            one-cycle completion pulse
//   busy             high from acceptance through the DONE/ERR cycle
//   misalign         high together with ready when a request is rejected
//   mem_addr         registered word address to memory
//   mem_we           registered write strobe, one cycle per store
//   mem_wdata        registered write data
//   mem_rdata        memory read data, valid MEM_LAT cycles after mem_addr
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for req; latches the request
// RD    | memory read in flight; counter runs MEM_LAT down to 0
// MERGE | insert store lane(s) into the read word
// WR    | mem_we high for exactly one cycle
// DONE  | ready pulse; load result already in rdata
// ERR   | ready + misalign pulse; no memory access
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic              busy,
    output logic              misalign,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD    = 3'd1;
    localparam logic [2:0] S_MERGE = 3'd2;
    localparam logic [2:0] S_WR    = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             we_q;
    logic [1:0]       size_q;
    logic [1:0]       lane_q;
    logic [31:0]      wdata_q;
    logic [31:0]      buf_q;

    logic             mis_in;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [31:0]      ld_val;
    logic [31:0]      merged;

    // Alignment check on the live request inputs, used only in IDLE.
    always_comb begin
        mis_in = 1'b0;
        case (size)
            2'b00:   mis_in = (addr[1:0] != 2'b00);
            2'b01:   mis_in = addr[0];
            2'b10:   mis_in = 1'b0;
            default: mis_in = 1'b1;
        endcase
    end

    // Lane extraction straight from mem_rdata so rdata lands on the edge
    // that enters DONE.
    always_comb begin
        rd_byte = mem_rdata[7:0];
        case (lane_q)
            2'd0: rd_byte = mem_rdata[7:0];
            2'd1: rd_byte = mem_rdata[15:8];
            2'd2: rd_byte = mem_rdata[23:16];
            2'd3: rd_byte = mem_rdata[31:24];
            default: rd_byte = mem_rdata[7:0];
        endcase
        rd_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'b01:   ld_val = {{16{rd_half[15]}}, rd_half};
            2'b10:   ld_val = {{24{rd_byte[7]}}, rd_byte};
            default: ld_val = mem_rdata;
        endcase
    end

    // Read-modify-write merge: only the addressed lane(s) take wdata.
    always_comb begin
        merged = buf_q;
        if (size_q == 2'b01) begin
            if (lane_q[1])
                merged[31:16] = wdata_q[15:0];
            else
                merged[15:0] = wdata_q[15:0];
        end else begin
            case (lane_q)
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                2'd3: merged[31:24] = wdata_q[7:0];
                default: merged = buf_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            lane_q    <= 2'b00;
            wdata_q   <= '0;
            buf_q     <= '0;
            rdata     <= '0;
            ready     <= 1'b0;
            busy      <= 1'b0;
            misalign  <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            ready    <= 1'b0;
            misalign <= 1'b0;
            mem_we   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        size_q  <= size;
                        lane_q  <= addr[1:0];
                        wdata_q <= wdata;
                        busy    <= 1'b1;
                        if (mis_in) begin
                            state    <= S_ERR;
                            ready    <= 1'b1;
                            misalign <= 1'b1;
                        end else begin
                            mem_addr <= {addr[ADDR_W-1:2], 2'b00};
                            if (we && size == 2'b00) begin
                                // Full-word store needs no read.
                                state     <= S_WR;
                                mem_we    <= 1'b1;
                                mem_wdata <= wdata;
                            end else begin
                                state <= S_RD;
                                cnt   <= CNT_W'(MEM_LAT);
                            end
                        end
                    end
                end
                S_RD: begin
                    if (cnt == '0) begin
                        buf_q <= mem_rdata;
                        if (we_q) begin
                            state <= S_MERGE;
                        end else begin
                            state <= S_DONE;
                            ready <= 1'b1;
                            rdata <= ld_val;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_MERGE: begin
                    state     <= S_WR;
                    mem_we    <= 1'b1;
                    mem_wdata <= merged;
                end
                S_WR: begin
                    state <= S_DONE;
                    ready <= 1'b1;
                end
                S_DONE, S_ERR: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam int ADDR_W  = 32;
    localparam int MEM_LAT = 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              req = 1'b0;
    logic              we = 1'b0;
    logic [1:0]        size = 2'b00;
    logic [ADDR_W-1:0] addr = '0;
    logic [31:0]       wdata = '0;
    logic [31:0]       rdata;
    logic              ready;
    logic              busy;
    logic              misalign;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    mem_access_unit #(.ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .we(we), .size(size),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
        .busy(busy), .misalign(misalign), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Fixed-latency synchronous memory, 16 words.
    logic [31:0] mem [16];
    logic [31:0] pipe [MEM_LAT];
    assign mem_rdata = pipe[MEM_LAT-1];

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        for (int i = 0; i < MEM_LAT; i++) pipe[i] = 32'h0;
        mem[4] = 32'h8899AABB;
        mem[5] = 32'h11223344;
        mem[6] = 32'h00007F01;
    end

    always @(posedge clk) begin
        pipe[0] <= mem[mem_addr[5:2]];
        for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
        if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          cyc;
        logic        mis;
        logic [31:0] rd;
    } rdy_t;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    rdy_t rdy_q[$];
    wr_t  wr_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every ready pulse and every write strobe against the queues.
    always @(negedge clk) begin
        if (reset_n) begin
            if (ready) begin
                if (rdy_q.size() == 0) begin
                    chk("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    rdy_t e;
                    e = rdy_q.pop_front();
                    chk("ready_cycle", 32'(cyc), 32'(e.cyc));
                    chk("misalign", {31'd0, misalign}, {31'd0, e.mis});
                    chk("rdata", rdata, e.rd);
                end
            end
            if (mem_we) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_mem_we", 32'd1, 32'd0);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    chk("mem_we_cycle", 32'(cyc), 32'(w.cyc));
                    chk("mem_addr", mem_addr, w.addr);
                    chk("mem_wdata", mem_wdata, w.data);
                end
            end
        end
    end

    // Wait (bounded) until the unit is back in IDLE; called at a negedge.
    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    // Issue one request at a negedge while the unit is idle; rn/wn are the
    // expected cycle numbers of ready and of the write strobe (wn=0: no write).
    task automatic issue(input logic w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input int rn, input logic mis,
                         input logic [31:0] rd, input int wn, input logic [31:0] wdat,
                         input bit poke);
        int k;
        rdy_t e;
        wr_t  x;
        k = cyc;
        e.cyc = k + rn; e.mis = mis; e.rd = rd;
        rdy_q.push_back(e);
        if (wn != 0) begin
            x.cyc = k + wn; x.addr = {a[31:2], 2'b00}; x.data = wdat;
            wr_q.push_back(x);
        end
        we = w; size = sz; addr = a; wdata = wd; req = 1'b1;
        @(posedge clk);
        #1;
        // Scramble inputs after acceptance; the latched copies must be used.
        req = 1'b0; we = ~w; size = ~sz; addr = 32'h0000_0023; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        if (poke) begin
            // A store request while busy must be dropped, not queued.
            we = 1'b1; size = 2'b10; addr = 32'h10; wdata = 32'h55; req = 1'b1;
            @(negedge clk);
            req = 1'b0;
        end
        wait_idle("op");
    endtask

    initial begin
        logic [31:0] last;
        repeat (3) @(negedge clk);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_ready", {31'd0, ready}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Loads
        issue(1'b0, 2'b00, 32'h10, 32'h0, 4, 1'b0, 32'h8899AABB, 0, 32'h0, 1'b1);
        issue(1'b0, 2'b10, 32'h13, 32'h0, 4, 1'b0, 32'hFFFFFF88, 0, 32'h0, 1'b0);
        issue(1'b0, 2'b10, 32'h10, 32'h0, 4, 1'b0, 32'hFFFFFFBB, 0, 32'h0, 1'b0);
        issue(1'b0, 2'b10, 32'h11, 32'h0, 4, 1'b0, 32'hFFFFFFAA, 0, 32'h0, 1'b0);
        issue(1'b0, 2'b01, 32'h12, 32'h0, 4, 1'b0, 32'hFFFF8899, 0, 32'h0, 1'b0);
        issue(1'b0, 2'b01, 32'h10, 32'h0, 4, 1'b0, 32'hFFFFAABB, 0, 32'h0, 1'b0);
        issue(1'b0, 2'b10, 32'h18, 32'h0, 4, 1'b0, 32'h00000001, 0, 32'h0, 1'b0);
        issue(1'b0, 2'b01, 32'h18, 32'h0, 4, 1'b0, 32'h00007F01, 0, 32'h0, 1'b0);
        last = 32'h00007F01;

        // Stores
        issue(1'b1, 2'b10, 32'h11, 32'h12345677, 6, 1'b0, last, 5, 32'h889977BB, 1'b0);
        issue(1'b1, 2'b00, 32'h10, 32'h8899AABB, 2, 1'b0, last, 1, 32'h8899AABB, 1'b0);
        issue(1'b1, 2'b01, 32'h12, 32'h0000CAFE, 6, 1'b0, last, 5, 32'hCAFEAABB, 1'b0);
        issue(1'b0, 2'b00, 32'h10, 32'h0, 4, 1'b0, 32'hCAFEAABB, 0, 32'h0, 1'b0);
        last = 32'hCAFEAABB;
        issue(1'b1, 2'b10, 32'h13, 32'h000000A5, 6, 1'b0, last, 5, 32'hA5FEAABB, 1'b0);
        issue(1'b0, 2'b10, 32'h13, 32'h0, 4, 1'b0, 32'hFFFFFFA5, 0, 32'h0, 1'b0);
        last = 32'hFFFFFFA5;

        // Misaligned / illegal
        issue(1'b0, 2'b01, 32'h11, 32'h0, 1, 1'b1, last, 0, 32'h0, 1'b0);
        issue(1'b1, 2'b00, 32'h12, 32'h11111111, 1, 1'b1, last, 0, 32'h0, 1'b0);
        issue(1'b0, 2'b11, 32'h10, 32'h0, 1, 1'b1, last, 0, 32'h0, 1'b0);
        issue(1'b0, 2'b00, 32'h13, 32'h0, 1, 1'b1, last, 0, 32'h0, 1'b0);
        issue(1'b1, 2'b01, 32'h17, 32'h2222, 1, 1'b1, last, 0, 32'h0, 1'b0);
        chk("mem_word4", mem[4], 32'hA5FEAABB);

        // Reset in the middle of an SB read phase
        we = 1'b1; size = 2'b10; addr = 32'h15; wdata = 32'h000000EE; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'h0);
        chk("abort_ready", {31'd0, ready}, 32'h0);
        chk("abort_mem_we", {31'd0, mem_we}, 32'h0);
        chk("abort_mem_addr", mem_addr, 32'h0);
        chk("abort_mem_wdata", mem_wdata, 32'h0);
        chk("abort_rdata", rdata, 32'h0);
        chk("abort_misalign", {31'd0, misalign}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_mem_word5", mem[5], 32'h11223344);
        issue(1'b0, 2'b00, 32'h14, 32'h0, 4, 1'b0, 32'h11223344, 0, 32'h0, 1'b0);

        repeat (4) @(negedge clk);
        chk("rdy_queue_empty", 32'(rdy_q.size()), 32'd0);
        chk("wr_queue_empty", 32'(wr_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
